// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array edge logic.
//   feeder_state_e : sequencing states of the skew feeder
//   lane_lsb()     : bit offset of a lane inside a packed row vector
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } feeder_state_e;

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/skew_lane.sv
// One lane of the skew stage: a depth_p-deep {valid, data} delay line that
// shifts only on adv_i.
//   clk_i, reset_i  : clock, async active-low reset
//   adv_i           : shift enable (array advance)
//   valid_i, data_i : stage-0 load value (bubbles arrive as valid 0, data 0)
//   valid_o, data_o : last stage, presented to the array edge
module skew_lane #(
  parameter int width_p = 8,
  parameter int depth_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               adv_i,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               valid_o,
  output logic [width_p-1:0] data_o
);

  logic [depth_p-1:0] r_valid;
  logic [width_p-1:0] r_data [depth_p];

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_valid <= '0;
      for (int k = 0; k < depth_p; k++) r_data[k] <= '0;
    end else if (adv_i) begin
      r_valid[0] <= valid_i;
      r_data[0]  <= data_i;
      for (int k = 1; k < depth_p; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_data[k]  <= r_data[k-1];
      end
    end
  end

  assign valid_o = r_valid[depth_p-1];
  assign data_o  = r_data[depth_p-1];

endmodule

// File: rtl/skew_feeder.sv
// Input skew stage for the systolic array. Lane i of each accepted row vector
// is delayed by i advance cycles so the array edge sees a diagonal wavefront;
// after the last vector of a tile, zeros are flushed until the last element
// reaches the far lane, then done_o pulses.
//   clk_i, reset_i           : clock, async active-low reset
//   valid_i, last_i, data_i  : upstream row vector (packed, lane 0 in LSBs)
//   ready_o                  : vector accepted when valid_i & ready_o
//   ready_i                  : array advance enable; low freezes everything
//   valid_o, data_o          : skewed per-lane valid/data at the array edge
//   busy_o                   : tile in progress or data still in flight
//   done_o                   : one-cycle pulse when the flush completes
//
// state  | meaning
// IDLE   | no tile open, pipeline drained
// STREAM | tile open, accepting vectors (bubbles allowed)
// FLUSH  | last vector taken, shifting in bubbles until it reaches the far lane
module skew_feeder
  import systolic_pkg::*;
#(
  parameter int width_p = 8,
  parameter int lanes_p = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       valid_i,
  input  logic                       last_i,
  input  logic [width_p*lanes_p-1:0] data_i,
  output logic                       ready_o,
  input  logic                       ready_i,
  output logic [lanes_p-1:0]         valid_o,
  output logic [width_p*lanes_p-1:0] data_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int CNT_W = $clog2(lanes_p);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(lanes_p - 2);

  feeder_state_e    r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_done, w_exit;
  logic             w_accept;

  assign ready_o  = ready_i & (r_state != FLUSH);
  assign w_accept = valid_i & ready_o;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_exit      = 1'b0;
    case (r_state)
      IDLE, STREAM: begin
        if (w_accept) begin
          if (last_i) begin
            w_state_nxt = FLUSH;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = STREAM;
          end
        end
      end
      FLUSH: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
          w_exit      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // done_o is simply the registered exit condition, so it drops on the next
  // advance and freezes with everything else during a stall.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else if (ready_i) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_exit;
    end
  end

  for (genvar i = 0; i < lanes_p; i++) begin : g_lane
    localparam int LSB = lane_lsb(i, width_p);
    logic [width_p-1:0] w_lane_in;

    // Non-accepted cycles load a zero bubble so data_o is zero wherever
    // valid_o is low.
    assign w_lane_in = w_accept ? data_i[LSB +: width_p] : '0;

    skew_lane #(
      .width_p (width_p),
      .depth_p (i + 1)
    ) u_lane (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .adv_i   (ready_i),
      .valid_i (w_accept),
      .data_i  (w_lane_in),
      .valid_o (valid_o[i]),
      .data_o  (data_o[LSB +: width_p])
    );
  end

  // On FLUSH exit the only valid stage left is the far lane's output register,
  // so watching valid_o is enough to cover every stage.
  assign busy_o = (r_state != IDLE) | (|valid_o);
  assign done_o = r_done;

endmodule

// File: tb/tb_skew_feeder.sv
module tb_skew_feeder;
  localparam int W = 8;
  localparam int L = 4;

  logic           clk_i   = 1'b0;
  logic           reset_i = 1'b0;
  logic           valid_i = 1'b0;
  logic           last_i  = 1'b0;
  logic           ready_i = 1'b1;
  logic [W*L-1:0] data_i  = '0;
  logic           ready_o;
  logic [L-1:0]   valid_o;
  logic [W*L-1:0] data_o;
  logic           busy_o;
  logic           done_o;

  skew_feeder #(.width_p(W), .lanes_p(L)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .valid_i (valid_i),
    .last_i  (last_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .ready_i (ready_i),
    .valid_o (valid_o),
    .data_o  (data_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         lane;
    int         stamp;
    logic [7:0] d;
  } item_t;

  item_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_adv    = 0;
  int    done_stamp = 0;
  bit    tile_open = 0;
  bit    done_pending = 0;
  int    ready_low_cnt = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_ready(input bit r);
    return r && !(done_pending && n_adv < done_stamp);
  endfunction

  task automatic check_outputs();
    logic [L-1:0]   exp_v;
    logic [W*L-1:0] exp_d;
    exp_v = '0;
    exp_d = '0;
    for (int k = sb.size() - 1; k >= 0; k--)
      if (sb[k].stamp < n_adv) sb.delete(k);
    foreach (sb[k])
      if (sb[k].stamp == n_adv) begin
        exp_v[sb[k].lane] = 1'b1;
        exp_d[sb[k].lane*W +: W] = sb[k].d;
      end
    chk_eq("valid_o", 32'(valid_o), 32'(exp_v));
    chk_eq("data_o", data_o, exp_d);
    chk_eq("ready_o", 32'(ready_o), 32'(model_ready(ready_i)));
    chk_eq("done_o", 32'(done_o), 32'(done_pending && n_adv == done_stamp));
    chk_eq("busy_o", 32'(busy_o), 32'(tile_open || (done_pending && n_adv <= done_stamp)));
    if (ready_i && !ready_o) ready_low_cnt++;
  endtask

  // Drive one cycle: inputs at posedge+1, check at negedge, update model.
  task automatic step(input bit v, input bit l, input logic [31:0] d, input bit r);
    bit    acc;
    item_t it;
    valid_i = v;
    last_i  = l;
    data_i  = d;
    ready_i = r;
    @(negedge clk_i);
    check_outputs();
    acc = v && model_ready(r);
    if (r) begin
      n_adv++;
      if (acc) begin
        for (int i = 0; i < L; i++) begin
          it.lane  = i;
          it.stamp = n_adv + i;
          it.d     = d[i*W +: W];
          sb.push_back(it);
        end
        if (l) begin
          tile_open    = 0;
          done_pending = 1;
          done_stamp   = n_adv + L - 1;
        end else begin
          tile_open = 1;
        end
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
  endtask

  task automatic reset_pulse(input string tag);
    #2 reset_i = 1'b0;
    #1;
    chk_eq({tag, "_valid"}, 32'(valid_o), 32'h0);
    chk_eq({tag, "_data"}, data_o, 32'h0);
    chk_eq({tag, "_done"}, 32'(done_o), 32'h0);
    chk_eq({tag, "_busy"}, 32'(busy_o), 32'h0);
    chk_eq({tag, "_ready"}, 32'(ready_o), 32'(ready_i));
    sb.delete();
    tile_open    = 0;
    done_pending = 0;
    @(posedge clk_i);
    #1 reset_i = 1'b1;
  endtask

  initial begin
    #2;
    chk_eq("rst_valid", 32'(valid_o), 32'h0);
    chk_eq("rst_data", data_o, 32'h0);
    chk_eq("rst_done", 32'(done_o), 32'h0);
    chk_eq("rst_busy", 32'(busy_o), 32'h0);
    chk_eq("rst_ready", 32'(ready_o), 32'h1);
    @(posedge clk_i);
    #1 reset_i = 1'b1;

    // single vector; valid_i held high during the flush must be ignored
    ready_low_cnt = 0;
    step(1'b1, 1'b1, 32'h04030201, 1'b1);
    step(1'b1, 1'b0, 32'hFFFFFFFF, 1'b1);
    idle(5);
    chk_eq("ready_low_cycles", 32'(ready_low_cnt), 32'd3);

    // back-to-back
    step(1'b1, 1'b0, 32'h13121110, 1'b1);
    step(1'b1, 1'b0, 32'h23222120, 1'b1);
    step(1'b1, 1'b1, 32'h33323130, 1'b1);
    idle(6);

    // bubble between two vectors
    step(1'b1, 1'b0, 32'hA3A2A1A0, 1'b1);
    step(1'b0, 1'b0, 32'h55555555, 1'b1);
    step(1'b1, 1'b1, 32'hB3B2B1B0, 1'b1);
    idle(6);

    // stall during flush, with valid_i asserted while stalled
    step(1'b1, 1'b1, 32'hC3C2C1C0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h77777777, 1'b0);
    step(1'b1, 1'b0, 32'h77777777, 1'b0);
    idle(6);

    // async reset mid-stream, then resume
    step(1'b1, 1'b0, 32'hD3D2D1D0, 1'b1);
    step(1'b1, 1'b0, 32'hE3E2E1E0, 1'b1);
    reset_pulse("rst_stream");
    idle(3);
    step(1'b1, 1'b1, 32'h44434241, 1'b1);
    idle(6);

    // async reset mid-flush: no done pulse, then a fresh tile
    step(1'b1, 1'b1, 32'hF3F2F1F0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    reset_pulse("rst_flush");
    idle(5);
    step(1'b1, 1'b0, 32'h64636261, 1'b1);
    step(1'b1, 1'b1, 32'h74737271, 1'b1);
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/skew_feeder.md
# skew_feeder

Input skew stage for the systolic array. It accepts full row vectors of `lanes_p` elements in the packed format the SIPO emits, and delays lane i by i advance cycles. The array edge therefore receives a diagonal wavefront. After the final vector it flushes zeros so the last element reaches the far lane, then pulses `done_o`.

## Interface
- `width_p`, 8: element width in bits.
- `lanes_p`, 8: lane count, equal to the array edge length; must be ≥ 2.
- `clk_i`  in  1  single clock; all state updates on posedge.
- `reset_i`  in  1  asynchronous, active-low reset; clears all state immediately.
- `valid_i`  in  1  upstream vector valid.
- `last_i`  in  1  qualifies `valid_i`; marks the final vector of a tile.
- `data_i`  in  `width_p*lanes_p`  lane i is `data_i[(i+1)*width_p-1 : i*width_p]`.
- `ready_o`  out  1  vector accepted on an edge where `valid_i & ready_o`.
- `ready_i`  in  1  array advance enable; low stalls the whole block.
- `valid_o`  out  `lanes_p`  per-lane valid at the array edge.
- `data_o`  out  `width_p*lanes_p`  skewed lane data, same packing as `data_i`; zero where `valid_o[i]=0`.
- `busy_o`  out  1  state ≠ IDLE or any stage valid.
- `done_o`  out  1  one-cycle pulse when the flush completes.

## Operation
- Advance (adv) is `ready_i`. With `ready_i=0`, every register holds, including state, counter and `done_o`.
- Lane i is a delay line of i+1 registers. Each stage holds {valid, data}.
- On adv, stage 0 of every lane loads `data_i` lane i if a vector is accepted. Otherwise it loads a bubble: valid 0, data 0.
- `ready_o = ready_i & (state != FLUSH)`. This is combinational, with no dependence on `valid_i`.
- States are IDLE, STREAM and FLUSH.
  - IDLE → STREAM: accept with `last_i=0`.
  - IDLE or STREAM → FLUSH: accept with `last_i=1`. The flush counter is cleared at the same time.
  - STREAM holds on bubbles (`valid_i=0`); a bubble propagates diagonally like data.
  - FLUSH: no accepts. Bubbles are inserted on each adv and the counter increments.
  - FLUSH → IDLE: on the adv where the counter equals `lanes_p-2` (i.e. the `lanes_p-1`th flush advance).
- Flush counter is `$clog2(lanes_p)` bits. It never wraps: it is cleared on FLUSH entry and stops at exit.
- `done_o` is registered. It is 1 for exactly one cycle after the FLUSH→IDLE edge, then clears on the next adv.
- The pipeline is empty in IDLE.
- `last_i` is ignored unless `valid_i & ready_o`.
- Reset mid-operation: state goes to IDLE, all stage valids and data go to 0, counter 0, `done_o` 0. Any partial tile is discarded.

## Timing
- Reset values:
  - `valid_o=0`, `data_o=0`, `done_o=0`, `busy_o=0`.
  - `ready_o` follows `ready_i`, since the block resets to IDLE.
- With no stalls, a vector accepted on edge E appears on lane i after edge E+i. Lane 0 is visible the cycle after acceptance.
- Throughput is one vector per cycle in IDLE/STREAM.
- From a last-vector accept, `ready_o` is low for `lanes_p-1` advance cycles.
- `done_o` is high in the same cycle that lane `lanes_p-1` shows the last vector.
- A stall of s cycles delays all subsequent outputs and `done_o` by s.

## Structure
- `systolic_pkg` holds:
  - `feeder_state_e` enum {IDLE, STREAM, FLUSH};
  - the shared lane-packing helper constant `lane_lsb(i) = i*width_p`.
- Sub-module `skew_lane`:
  - parameters `width_p`, `depth_p`;
  - ports `clk_i`, `reset_i`, `adv_i`, `valid_i`, `data_i`, `valid_o`, `data_o`;
  - instantiated by a generate loop with `depth_p = i+1`.
- FSM, counter and handshake live in `skew_feeder`.

## Test plan
All tests use `lanes_p=4` and `width_p=8`.
- **Reset:** drive `reset_i=0` asynchronously mid-STREAM → outputs clear immediately. `valid_o=0000`, `data_o=0`, `done_o=0`, `busy_o=0` without waiting for a clock edge.
- **Single vector:** `data_i=0x04030201` with `last_i=1`, `ready_i=1` → over 4 cycles:
  - `valid_o` = 0001, 0010, 0100, 1000;
  - the active lane carries 01, 02, 03, 04;
  - `ready_o` is low for 3 cycles;
  - `done_o` is high with 1000.
- **Back-to-back:** `0x13121110`, `0x23222120`, `0x33323130` (last) → wavefront with no gaps.
  - Lane 0: 10, 20, 30.
  - Lane 3: 13, 23, 33, starting 3 cycles after lane 0.
  - `done_o` is high with lane 3 = 33.
- **Bubble:** vector A, one cycle `valid_i=0`, then vector B (last) → a zero-data bubble with `valid_o[i]=0` appears in each lane i exactly 1 cycle after A in that lane.
- **Stall:** hold `ready_i=0` for 2 cycles during FLUSH → `valid_o`/`data_o` hold, `ready_o=0`, and `done_o` is delayed by 2 cycles.
- **Reset mid-flush:** pulse reset during FLUSH → IDLE; `ready_o=ready_i`; no `done_o` pulse; a new vector streams normally.
